uart_tx_sched: RTL
==================

Name: uart_tx_sched

Overview:
Transmit sequencer for the UART core. It accepts a byte from the APB register block via a one-cycle write strobe and holds it in a one-deep holding register. It then moves the byte into a shift register and serialises it onto txd as start, data (LSB first), optional parity, and stop. It owns the baud-tick generation derived from the programmed baud value and reports buffer status back to the register block.

Parameters:
DATA_W, 8, data bits per frame
BAUD_W, 8, width of baud divisor
OVERSAMPLE, 16, baud ticks per bit period

Ports:
pclk  input  1  system clock, rising edge
presetn  input  1  reset
baud_val  input  BAUD_W  divisor; tick period = baud_val+1 pclk cycles
tx_wr  input  1  one-cycle strobe: load tx_data into holding register
tx_data  input  DATA_W  byte to transmit
tx_rdy  output  1  1 = holding register empty, tx_wr will be accepted
tx_busy  output  1  1 = frame in progress (FSM not IDLE)
tx_ovr  output  1  one-cycle pulse: tx_wr arrived while tx_rdy=0, data dropped
baud_tick  output  1  one-cycle tick pulse, exported for the RX side
txd  output  1  serial line, idle high

Behaviour:
- Reset: presetn is asynchronous, active-low. All of the following hold immediately on assertion, including mid-frame; any frame in progress is abandoned.
  - txd=1, tx_rdy=1, tx_busy=0, tx_ovr=0, baud_tick=0.
  - FSM=IDLE; all counters 0; holding register empty.
- Baud generator:
  - Down-counter loads baud_val and decrements each cycle.
  - baud_tick=1 for one cycle when the count is 0, then reloads.
  - baud_val=0 gives a tick every cycle.
  - baud_val is sampled only at reload; a mid-frame change takes effect at the next reload.
  - The counter is forced to reload on the IDLE->START transition, so every bit lasts exactly OVERSAMPLE*(baud_val+1) cycles.
- Holding register:
  - tx_wr with tx_rdy=1 latches tx_data; tx_rdy=0 from the next cycle.
  - tx_wr with tx_rdy=0 drops the data and pulses tx_ovr on the next cycle.
  - tx_wr in the same cycle as the hold->shift transfer counts as tx_rdy=0 and is dropped with tx_ovr.
- FSM states: IDLE, START, DATA, PARITY, STOP. A sample counter (0..OVERSAMPLE-1) advances on baud_tick; a bit ends on the tick where the sample counter is OVERSAMPLE-1.
  - IDLE: txd=1. If the holding register is full: copy it to the shift register, mark hold empty (tx_rdy=1 next cycle), clear counters, go to START. txd=0 on the cycle after transfer (tx_wr at cycle N into an idle block gives txd low at N+2).
  - START: txd=0 for one bit, then DATA.
  - DATA: txd=shift[0]; shift right at each bit end; bit counter 0..DATA_W-1. After the last bit go to PARITY if enabled, else STOP.
  - PARITY: one bit, then STOP.
  - STOP: txd=1 for one bit. At the end go directly to START if the holding register is full (back-to-back frames, no idle gap), else go to IDLE.
- tx_busy = (state != IDLE).

Optional Feature:
UART_TX_PARITY_EN:
- Defined: adds input parity_odd (1 bit) and the PARITY state. The parity bit is the XOR of the data bits, inverted when parity_odd=1. Frame = 1+DATA_W+1+1 bits.
- Undefined: no port, no PARITY state; frame = 1+DATA_W+1 bits.

Decomposition:
- Shared package uart_pkg: FSM state encodings, OVERSAMPLE default, IDLE_LEVEL=1'b1, START_LEVEL=1'b0.
- Sub-module uart_baud_gen: divisor counter, reload input, baud_tick output. It is reused by the future RX sampler.

Test Plan:
- Reset mid-frame: assert presetn=0 during DATA bit 3 -> txd=1, tx_rdy=1, tx_busy=0 with no clock edge; after release, no residual frame.
- Single frame: baud_val=3, write 0xA5 -> start bit low at cycle +2, each bit 64 cycles. txd = 0,1,0,1,0,0,1,0,1,1 (start, LSB first, stop); tx_rdy high 1 cycle after start.
- Back-to-back: write 0x55, then write 0x0F while the first frame is in DATA -> second start bit immediately follows the first stop bit, no gap; tx_busy stays 1 throughout.
- Overrun: with the holding register full, pulse tx_wr with 0xFF -> tx_ovr 1-cycle pulse; transmitted bytes unchanged.
- Divisor edge: baud_val=0 -> baud_tick every cycle, bit = 16 cycles. Change baud_val 0->7 mid-frame -> current tick period completes, new period from the next reload.
- Parity (UART_TX_PARITY_EN): 0xA5, parity_odd=0 -> parity bit 0; parity_odd=1 -> parity bit 1; frame is 11 bits.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: constants and TX FSM encoding shared by the UART TX and RX blocks.
// Optional feature macro: UART_TX_PARITY_EN adds the PARITY state.
package uart_pkg;

  localparam int   OVERSAMPLE_DFLT = 16;
  localparam logic IDLE_LEVEL      = 1'b1;
  localparam logic START_LEVEL     = 1'b0;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
    ST_PARITY = 3'd3,
`endif
    ST_STOP   = 3'd4
  } tx_state_e;

endpackage

// File: rtl/uart_baud_gen.sv
// uart_baud_gen: programmable tick divider shared by the TX scheduler and the
// RX sampler. Tick period is baud_val+1 clocks; baud_val is only sampled at
// reload, so a change takes effect at the start of the next period.
module uart_baud_gen #(
  parameter int BAUD_W = 8
) (
  input  logic              pclk,
  input  logic              presetn,
  input  logic [BAUD_W-1:0] baud_val,
  input  logic              reload,
  output logic              baud_tick
);

  logic [BAUD_W-1:0] cnt_q, cnt_d;
  logic              armed_q, armed_d;

  // Count down to zero then reload; an explicit reload restarts the period.
  always_comb begin
    armed_d = 1'b1;
    cnt_d   = cnt_q - 1'b1;
    if (reload || (cnt_q == '0)) begin
      cnt_d = baud_val;
    end
  end

  // Counter register; armed_q keeps the tick quiet while still at reset value.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      cnt_q   <= '0;
      armed_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      armed_q <= armed_d;
    end
  end

  assign baud_tick = armed_q & (cnt_q == '0);

endmodule

// File: rtl/uart_tx_sched.sv
// uart_tx_sched: UART transmit sequencer. One-deep holding register feeding a
// shift register, serialised as start, data (LSB first), optional parity, stop.
// Optional feature macro: UART_TX_PARITY_EN (parity_odd port + PARITY state).
//
// state  | meaning
// IDLE   | line idle high, waiting for the holding register to fill
// START  | driving the start bit
// DATA   | driving shift[0], one data bit per bit period
// PARITY | driving the parity bit (UART_TX_PARITY_EN only)
// STOP   | driving the stop bit; chains straight into START if data waits
module uart_tx_sched
  import uart_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int BAUD_W     = 8,
  parameter int OVERSAMPLE = OVERSAMPLE_DFLT
) (
  input  logic              pclk,
  input  logic              presetn,
  input  logic [BAUD_W-1:0] baud_val,
  input  logic              tx_wr,
  input  logic [DATA_W-1:0] tx_data,
`ifdef UART_TX_PARITY_EN
  input  logic              parity_odd,
`endif
  output logic              tx_rdy,
  output logic              tx_busy,
  output logic              tx_ovr,
  output logic              baud_tick,
  output logic              txd
);

  localparam int SAMP_W = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
  localparam int BIT_W  = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [SAMP_W-1:0] SAMP_LAST = SAMP_W'(OVERSAMPLE - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_W - 1);

  tx_state_e         state_q, state_d;
  logic              hold_full_q, hold_full_d;
  logic [DATA_W-1:0] hold_data_q, hold_data_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [SAMP_W-1:0] samp_q, samp_d;
  logic [BIT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic              ovr_q, ovr_d;
`ifdef UART_TX_PARITY_EN
  logic              parity_q, parity_d;
`endif

  logic bit_end;
  logic xfer;
  logic reload;

  // A bit period closes on the last oversample tick; the hold register drains
  // into the shifter from IDLE or at the very end of a stop bit.
  assign bit_end = baud_tick && (samp_q == SAMP_LAST) && (state_q != ST_IDLE);
  assign xfer    = hold_full_q &&
                   ((state_q == ST_IDLE) || ((state_q == ST_STOP) && bit_end));
  // Only an idle start realigns the divider; chained frames keep its phase.
  assign reload  = hold_full_q && (state_q == ST_IDLE);

  uart_baud_gen #(
    .BAUD_W (BAUD_W)
  ) u_baud_gen (
    .pclk      (pclk),
    .presetn   (presetn),
    .baud_val  (baud_val),
    .reload    (reload),
    .baud_tick (baud_tick)
  );

  // FSM state register.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (hold_full_q) state_d = ST_START;
      ST_START:  if (bit_end) state_d = ST_DATA;
      ST_DATA: begin
        if (bit_end && (bit_cnt_q == BIT_LAST)) begin
`ifdef UART_TX_PARITY_EN
          state_d = ST_PARITY;
`else
          state_d = ST_STOP;
`endif
        end
      end
`ifdef UART_TX_PARITY_EN
      ST_PARITY: if (bit_end) state_d = ST_STOP;
`endif
      ST_STOP:   if (bit_end) state_d = hold_full_q ? ST_START : ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // FSM outputs: line level per state and busy flag.
  always_comb begin
    tx_busy = (state_q != ST_IDLE);
    case (state_q)
      ST_START:  txd = START_LEVEL;
      ST_DATA:   txd = shift_q[0];
`ifdef UART_TX_PARITY_EN
      ST_PARITY: txd = parity_q;
`endif
      default:   txd = IDLE_LEVEL;
    endcase
  end

  // Datapath: holding register, shifter, sample/bit counters, overrun flag.
  always_comb begin
    hold_full_d = hold_full_q;
    hold_data_d = hold_data_q;
    shift_d     = shift_q;
    samp_d      = samp_q;
    bit_cnt_d   = bit_cnt_q;
    // A write while the hold is full (including the transfer cycle) is lost.
    ovr_d       = tx_wr && hold_full_q;
`ifdef UART_TX_PARITY_EN
    parity_d    = parity_q;
`endif

    if (xfer) begin
      hold_full_d = 1'b0;
    end else if (tx_wr && !hold_full_q) begin
      hold_full_d = 1'b1;
      hold_data_d = tx_data;
    end

    if (xfer) begin
      shift_d   = hold_data_q;
      samp_d    = '0;
      bit_cnt_d = '0;
`ifdef UART_TX_PARITY_EN
      parity_d  = (^hold_data_q) ^ parity_odd;
`endif
    end else begin
      if ((state_q != ST_IDLE) && baud_tick) begin
        samp_d = (samp_q == SAMP_LAST) ? '0 : samp_q + 1'b1;
      end
      if ((state_q == ST_DATA) && bit_end) begin
        shift_d   = shift_q >> 1;
        bit_cnt_d = (bit_cnt_q == BIT_LAST) ? '0 : bit_cnt_q + 1'b1;
      end
    end
  end

  // Datapath registers.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      hold_full_q <= 1'b0;
      hold_data_q <= '0;
      shift_q     <= '0;
      samp_q      <= '0;
      bit_cnt_q   <= '0;
      ovr_q       <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_q    <= 1'b0;
`endif
    end else begin
      hold_full_q <= hold_full_d;
      hold_data_q <= hold_data_d;
      shift_q     <= shift_d;
      samp_q      <= samp_d;
      bit_cnt_q   <= bit_cnt_d;
      ovr_q       <= ovr_d;
`ifdef UART_TX_PARITY_EN
      parity_q    <= parity_d;
`endif
    end
  end

  assign tx_rdy = ~hold_full_q;
  assign tx_ovr = ovr_q;

endmodule
